// File: rtl/match_pkg.sv
// Shared types and widths for the keypoint-matcher frame scheduler.
// Holds the scheduler state encoding and the counter/score widths.
package match_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      FLUSH,
      WAIT_MATCH
   } sched_state_e;

   localparam int KP_CNT_W   = 12;
   localparam int DROP_CNT_W = 16;
   localparam int SCORE_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Ports: clk, rst (async, active-high), clr, inc, count[W-1:0].
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/match_frame_sched.sv
// Frame scheduler in front of the keypoint matcher: admits one frame at a
// time, filters/caps keypoints, frames the matcher with start/end pulses.
// Ports: i_clk, i_rst, i_cfg_score_min, i_frame_start/end, i_kp_valid,
//  i_kp_score, i_match_frame_end -> o_kp_valid, o_match_start/end, o_busy,
//  o_kp_count, o_kp_capped, o_frame_dropped, o_drop_count, o_timeout.
module match_frame_sched
   import match_pkg::*;
#(
   parameter int MAX_KEYS       = 500,
   parameter int FLUSH_CYCLES   = 128,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [SCORE_W-1:0]    i_cfg_score_min,
   input  logic                  i_frame_start,
   input  logic                  i_frame_end,
   input  logic                  i_kp_valid,
   input  logic [SCORE_W-1:0]    i_kp_score,
   input  logic                  i_match_frame_end,
   output logic                  o_kp_valid,
   output logic                  o_match_start,
   output logic                  o_match_end,
   output logic                  o_busy,
   output logic [KP_CNT_W-1:0]   o_kp_count,
   output logic [KP_CNT_W-1:0]   o_kp_capped,
   output logic                  o_frame_dropped,
   output logic [DROP_CNT_W-1:0] o_drop_count,
   output logic                  o_timeout
);

   localparam int FL_W =
      (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int TO_W =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLUSH_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   sched_state_e    state, state_n;
   logic [FL_W-1:0] fcnt, fcnt_n;
   logic [TO_W-1:0] tcnt, tcnt_n;
   logic            drop_mode, drop_mode_n;
   logic            mstart_n, mend_n, tout_n, dropped_n;
   logic            kp_clr;
   logic            kp_pass, kp_fwd, kp_cap;

   // Keypoints of a dropped frame must never leak through.
   assign kp_pass = (state == COLLECT) && !drop_mode && i_kp_valid &&
                    (i_kp_score >= i_cfg_score_min);
   assign kp_fwd  = kp_pass && (o_kp_count < KP_CNT_W'(MAX_KEYS));
   assign kp_cap  = kp_pass && !(o_kp_count < KP_CNT_W'(MAX_KEYS));

   always_comb begin
      state_n     = state;
      fcnt_n      = fcnt;
      tcnt_n      = tcnt;
      drop_mode_n = drop_mode;
      mstart_n    = 1'b0;
      mend_n      = 1'b0;
      tout_n      = 1'b0;
      dropped_n   = 1'b0;
      kp_clr      = 1'b0;
      if (i_frame_end) drop_mode_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_frame_start) begin
               mstart_n    = 1'b1;
               kp_clr      = 1'b1;
               drop_mode_n = 1'b0;
               fcnt_n      = FL_LOAD;
               state_n     = i_frame_end ? FLUSH : COLLECT;
            end
         end
         COLLECT: begin
            if (i_frame_start) begin
               // Missing end: close current frame, reject the new one.
               dropped_n   = 1'b1;
               drop_mode_n = 1'b1;
               fcnt_n      = FL_LOAD;
               state_n     = FLUSH;
            end else if (i_frame_end) begin
               fcnt_n  = FL_LOAD;
               state_n = FLUSH;
            end
         end
         FLUSH: begin
            if (fcnt == '0) begin
               mend_n  = 1'b1;
               tcnt_n  = '0;
               state_n = WAIT_MATCH;
            end else begin
               fcnt_n = fcnt - 1'b1;
            end
            if (i_frame_start) begin
               dropped_n   = 1'b1;
               drop_mode_n = !i_frame_end;
            end
         end
         WAIT_MATCH: begin
            if (i_match_frame_end) begin
               state_n = IDLE;
            end else if (tcnt == TO_LAST) begin
               tout_n  = 1'b1;
               state_n = IDLE;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
            if (i_frame_start) begin
               dropped_n   = 1'b1;
               drop_mode_n = !i_frame_end;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state           <= IDLE;
         fcnt            <= '0;
         tcnt            <= '0;
         drop_mode       <= 1'b0;
         o_kp_valid      <= 1'b0;
         o_match_start   <= 1'b0;
         o_match_end     <= 1'b0;
         o_busy          <= 1'b0;
         o_frame_dropped <= 1'b0;
         o_timeout       <= 1'b0;
      end else begin
         state           <= state_n;
         fcnt            <= fcnt_n;
         tcnt            <= tcnt_n;
         drop_mode       <= drop_mode_n;
         o_kp_valid      <= kp_fwd;
         o_match_start   <= mstart_n;
         o_match_end     <= mend_n;
         o_busy          <= (state_n != IDLE);
         o_frame_dropped <= dropped_n;
         o_timeout       <= tout_n;
      end
   end

   sat_counter #(.W(KP_CNT_W)) u_kp_count (
      .clk   (i_clk),
      .rst   (i_rst),
      .clr   (kp_clr),
      .inc   (kp_fwd),
      .count (o_kp_count)
   );

   sat_counter #(.W(KP_CNT_W)) u_kp_capped (
      .clk   (i_clk),
      .rst   (i_rst),
      .clr   (kp_clr),
      .inc   (kp_cap),
      .count (o_kp_capped)
   );

   sat_counter #(.W(DROP_CNT_W)) u_drop_count (
      .clk   (i_clk),
      .rst   (i_rst),
      .clr   (1'b0),
      .inc   (dropped_n),
      .count (o_drop_count)
   );

endmodule

// File: tb/tb_match_frame_sched.sv
// Directed self-checking bench for match_frame_sched.
// Timeout shortened to 64 cycles; flush stays at 128.
module tb_match_frame_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cfg_min = '0;
   logic        f_start = 1'b0;
   logic        f_end = 1'b0;
   logic        kp_valid = 1'b0;
   logic [7:0]  kp_score = '0;
   logic        m_end_in = 1'b0;
   logic        kp_valid_o;
   logic        m_start_o;
   logic        m_end_o;
   logic        busy_o;
   logic [11:0] kp_count_o;
   logic [11:0] kp_capped_o;
   logic        dropped_o;
   logic [15:0] drop_count_o;
   logic        timeout_o;

   int checks = 0;
   int errors = 0;
   int n_fwd = 0;
   int n_mend = 0;
   int base;

   match_frame_sched #(
      .MAX_KEYS       (500),
      .FLUSH_CYCLES   (128),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_cfg_score_min   (cfg_min),
      .i_frame_start     (f_start),
      .i_frame_end       (f_end),
      .i_kp_valid        (kp_valid),
      .i_kp_score        (kp_score),
      .i_match_frame_end (m_end_in),
      .o_kp_valid        (kp_valid_o),
      .o_match_start     (m_start_o),
      .o_match_end       (m_end_o),
      .o_busy            (busy_o),
      .o_kp_count        (kp_count_o),
      .o_kp_capped       (kp_capped_o),
      .o_frame_dropped   (dropped_o),
      .o_drop_count      (drop_count_o),
      .o_timeout         (timeout_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (kp_valid_o) n_fwd++;
      if (m_end_o) n_mend++;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_kp(input logic [7:0] s);
      kp_valid = 1'b1;
      kp_score = s;
      cyc(1);
      kp_valid = 1'b0;
   endtask

   task automatic start_frame();
      f_start = 1'b1;
      cyc(1);
      f_start = 1'b0;
   endtask

   task automatic end_frame(input string tag);
      f_end = 1'b1;
      cyc(1);
      f_end = 1'b0;
      cyc(127);
      chk({tag, "_mend_early"}, 32'(m_end_o), 0);
      cyc(1);
      chk({tag, "_mend"}, 32'(m_end_o), 1);
   endtask

   task automatic ack(input string tag);
      m_end_in = 1'b1;
      cyc(1);
      m_end_in = 1'b0;
      chk({tag, "_idle"}, 32'(busy_o), 0);
   endtask

   initial begin
      cyc(2);
      chk("rst_kpv", 32'(kp_valid_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_mstart", 32'(m_start_o), 0);
      chk("rst_mend", 32'(m_end_o), 0);
      chk("rst_cnt", 32'(kp_count_o), 0);
      chk("rst_drop", 32'(drop_count_o), 0);
      rst = 1'b0;
      cyc(2);

      // 1: basic frame
      cfg_min = 8'd20;
      base = n_fwd;
      start_frame();
      chk("t1_mstart", 32'(m_start_o), 1);
      chk("t1_busy", 32'(busy_o), 1);
      for (int i = 0; i < 10; i++) send_kp(8'd50);
      chk("t1_mstart_pulse", 32'(m_start_o), 0);
      end_frame("t1");
      chk("t1_fwd", 32'(n_fwd - base), 10);
      chk("t1_busy_wait", 32'(busy_o), 1);
      ack("t1");
      chk("t1_cnt", 32'(kp_count_o), 10);

      // 2: threshold boundary
      cfg_min = 8'd100;
      base = n_fwd;
      start_frame();
      send_kp(8'd99);
      send_kp(8'd100);
      send_kp(8'd255);
      send_kp(8'd0);
      end_frame("t2");
      ack("t2");
      chk("t2_fwd", 32'(n_fwd - base), 2);
      chk("t2_cnt", 32'(kp_count_o), 2);

      // 3: per-frame cap
      cfg_min = 8'd0;
      base = n_fwd;
      start_frame();
      kp_valid = 1'b1;
      kp_score = 8'd7;
      cyc(600);
      kp_valid = 1'b0;
      end_frame("t3");
      ack("t3");
      chk("t3_fwd", 32'(n_fwd - base), 500);
      chk("t3_cnt", 32'(kp_count_o), 500);
      chk("t3_capped", 32'(kp_capped_o), 100);

      // 4: frame arriving during WAIT_MATCH is dropped
      base = n_fwd;
      start_frame();
      send_kp(8'd9);
      end_frame("t4a");
      f_start = 1'b1;
      cyc(1);
      f_start = 1'b0;
      chk("t4_dropped", 32'(dropped_o), 1);
      chk("t4_dcount", 32'(drop_count_o), 1);
      chk("t4_mstart", 32'(m_start_o), 0);
      for (int i = 0; i < 5; i++) send_kp(8'd80);
      chk("t4_drop_pulse", 32'(dropped_o), 0);
      f_end = 1'b1;
      cyc(1);
      f_end = 1'b0;
      ack("t4a");
      chk("t4_fwd", 32'(n_fwd - base), 1);
      chk("t4_cnt_hold", 32'(kp_count_o), 1);
      base = n_fwd;
      start_frame();
      chk("t4_readmit", 32'(m_start_o), 1);
      for (int i = 0; i < 3; i++) send_kp(8'd1);
      end_frame("t4b");
      ack("t4b");
      chk("t4b_fwd", 32'(n_fwd - base), 3);
      chk("t4b_cnt", 32'(kp_count_o), 3);
      chk("t4b_dcount", 32'(drop_count_o), 1);

      // 5: matcher never answers
      start_frame();
      end_frame("t5");
      cyc(63);
      chk("t5_tout_early", 32'(timeout_o), 0);
      chk("t5_busy", 32'(busy_o), 1);
      cyc(1);
      chk("t5_tout", 32'(timeout_o), 1);
      chk("t5_idle", 32'(busy_o), 0);
      cyc(1);
      chk("t5_tout_pulse", 32'(timeout_o), 0);

      // 6: empty frame, then reset mid-COLLECT
      f_start = 1'b1;
      f_end = 1'b1;
      cyc(1);
      f_start = 1'b0;
      f_end = 1'b0;
      chk("t6_mstart", 32'(m_start_o), 1);
      chk("t6_busy", 32'(busy_o), 1);
      cyc(127);
      chk("t6_mend_early", 32'(m_end_o), 0);
      cyc(1);
      chk("t6_mend", 32'(m_end_o), 1);
      chk("t6_cnt", 32'(kp_count_o), 0);
      ack("t6");
      start_frame();
      kp_valid = 1'b1;
      kp_score = 8'd5;
      cyc(3);
      chk("t6_pre_cnt", 32'(kp_count_o), 3);
      base = n_mend;
      rst = 1'b1;
      #1;
      chk("t6_rst_kpv", 32'(kp_valid_o), 0);
      chk("t6_rst_busy", 32'(busy_o), 0);
      chk("t6_rst_cnt", 32'(kp_count_o), 0);
      chk("t6_rst_drop", 32'(drop_count_o), 0);
      cyc(1);
      chk("t6_rst_edge_busy", 32'(busy_o), 0);
      kp_valid = 1'b0;
      rst = 1'b0;
      cyc(200);
      chk("t6_no_mend", 32'(n_mend - base), 0);
      chk("t6_after_busy", 32'(busy_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
